// File: rtl/err_chk_pkg.sv
// Shared types and helpers for the exhaustive error checker.
package err_chk_pkg;

  // Width of the settle-delay counter (supports SETTLE up to 15).
  localparam int SETTLE_CW = 4;

  // Working width of the absolute-difference helper; output words must fit.
  localparam int ABS_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Unsigned |a - b| without relying on signed wrap-around.
  function automatic logic [ABS_W-1:0] abs_diff_u(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/err_accum.sv
// Error accumulator: absolute difference of the two circuit outputs and the
// running max / violation count / first-violating-vector statistics.
module err_accum
  import err_chk_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [N_IN-1:0]  vec_i,
  input  logic [N_OUT-1:0] exact_i,
  input  logic [N_OUT-1:0] approx_i,
  output logic             viol_now,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    viol_cnt,
  output logic [N_IN-1:0]  first_viol,
  output logic             first_viol_v
);

  logic [N_OUT-1:0] err;
  logic [N_OUT-1:0] max_err_d,  max_err_q;
  logic [N_IN:0]    viol_cnt_d, viol_cnt_q;
  logic [N_IN-1:0]  first_viol_d, first_viol_q;
  logic             first_viol_v_d, first_viol_v_q;

  // Error of the current vector and whether it exceeds the threshold.
  always_comb begin
    err      = N_OUT'(abs_diff_u(ABS_W'(exact_i), ABS_W'(approx_i)));
    viol_now = (int'(err) > ET);
  end

  // Next statistics: clear on a new sweep, fold in the current error in CHECK.
  always_comb begin
    max_err_d      = max_err_q;
    viol_cnt_d     = viol_cnt_q;
    first_viol_d   = first_viol_q;
    first_viol_v_d = first_viol_v_q;
    if (clr) begin
      max_err_d      = '0;
      viol_cnt_d     = '0;
      first_viol_d   = '0;
      first_viol_v_d = 1'b0;
    end else if (en) begin
      if (err > max_err_q) max_err_d = err;
      if (viol_now) begin
        viol_cnt_d = viol_cnt_q + (N_IN+1)'(1);
        if (!first_viol_v_q) begin
          first_viol_d   = vec_i;
          first_viol_v_d = 1'b1;
        end
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err_q      <= '0;
      viol_cnt_q     <= '0;
      first_viol_q   <= '0;
      first_viol_v_q <= 1'b0;
    end else begin
      max_err_q      <= max_err_d;
      viol_cnt_q     <= viol_cnt_d;
      first_viol_q   <= first_viol_d;
      first_viol_v_q <= first_viol_v_d;
    end
  end

  assign max_err      = max_err_q;
  assign viol_cnt     = viol_cnt_q;
  assign first_viol   = first_viol_q;
  assign first_viol_v = first_viol_v_q;

endmodule

// File: rtl/exhaustive_error_checker.sv
// Sweeps every input vector through an exact and an approximate circuit in
// lock-step and reports max error, violation count, first violation and pass.
module exhaustive_error_checker
  import err_chk_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int ET     = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_o,
  input  logic [N_OUT-1:0] exact_i,
  input  logic [N_OUT-1:0] approx_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    viol_cnt,
  output logic [N_IN-1:0]  first_viol,
  output logic             first_viol_v
);

  // Terminal value of the settle counter (unused when SETTLE is 0).
  localparam logic [SETTLE_CW-1:0] SETTLE_LAST =
    SETTLE_CW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  state_t                 state_d, state_q;
  logic [N_IN-1:0]        vec_d, vec_q;
  logic [SETTLE_CW-1:0]   cnt_d, cnt_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic                   pass_d, pass_q;
  logic                   acc_clr;
  logic                   acc_en;
  logic                   viol_now;

  err_accum #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ET    (ET)
  ) u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (acc_clr),
    .en           (acc_en),
    .vec_i        (vec_q),
    .exact_i      (exact_i),
    .approx_i     (approx_i),
    .viol_now     (viol_now),
    .max_err      (max_err),
    .viol_cnt     (viol_cnt),
    .first_viol   (first_viol),
    .first_viol_v (first_viol_v)
  );

  // Sweep control: abort wins over everything, start only acts when not busy.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_DRIVE;
            vec_d   = '0;
            cnt_d   = '0;
            pass_d  = 1'b0;
            acc_clr = 1'b1;
          end
        end
        S_DRIVE: begin
          cnt_d   = '0;
          state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
          else                      cnt_d   = cnt_q + SETTLE_CW'(1);
        end
        S_CHECK: begin
          acc_en = 1'b1;
          if (vec_q == '1) begin
            // The last vector's verdict is folded in here, not from the old count.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (viol_cnt == '0) && !viol_now;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            state_d = S_DRIVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
  end

  // FSM state, vector/settle counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_o = vec_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;

endmodule
